// File: rtl/bridge_drv.sv
// Purpose : DRSSTC half-bridge gate driver. Dead time at every commutation, bursts start/stop on feedback edges, on-time limit, watchdog, latched OCD.
// Latency : gates/busy/fault are registered and reflect the state entered at that edge; en/ocd pass a 2-flop synchroniser first (en rise -> busy = 3 clk).
// Backpressure: none; free-running output stage. Optional macro BRIDGE_DRV_HALFCYCLE_CNT_EN adds the halfcycles burst counter output.
module bridge_drv #(
    parameter int DEADTIME_MAX   = 255,
    parameter int ONTIME_MAX     = 65535,
    parameter int HALFPERIOD_MAX = 1023
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  sgn_pre,
    input  logic                                  en,
    input  logic                                  ocd,
    input  logic [$clog2(DEADTIME_MAX+1)-1:0]     deadtime,
    input  logic [$clog2(ONTIME_MAX+1)-1:0]       ontime,
    output logic                                  gate_a,
    output logic                                  gate_b,
    output logic                                  busy,
    output logic                                  fault
`ifdef BRIDGE_DRV_HALFCYCLE_CNT_EN
    , output logic [$clog2(ONTIME_MAX+1)-1:0]     halfcycles
`endif
);

    localparam int DW = $clog2(DEADTIME_MAX + 1);
    localparam int OW = $clog2(ONTIME_MAX + 1);
    localparam int WW = $clog2(HALFPERIOD_MAX + 1);

    localparam logic [OW-1:0] OTC_MAX = OW'(ONTIME_MAX);
    // Last watchdog count value still spent in DRIVE; DRIVE lasts HALFPERIOD_MAX cycles without an edge.
    localparam logic [WW-1:0] WD_LAST = WW'(HALFPERIOD_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           en_meta_q, en_s_q;
    logic           ocd_meta_q, ocd_s_q;
    logic           ph_q, ph_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;
    logic [OW-1:0]  otc_q, otc_d;
    logic [WW-1:0]  wdc_q, wdc_d;
    logic           gate_a_q, gate_a_d;
    logic           gate_b_q, gate_b_d;
    logic           busy_q, busy_d;
    logic           fault_q, fault_d;
    logic           stop_req;
    logic           fb_edge;
    logic [OW-1:0]  otc_inc;
`ifdef BRIDGE_DRV_HALFCYCLE_CNT_EN
    logic [OW-1:0]  hc_q, hc_d;
`endif

    // Two-flop synchronisers for the asynchronous interrupter and overcurrent inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_meta_q  <= 1'b0;
            en_s_q     <= 1'b0;
            ocd_meta_q <= 1'b0;
            ocd_s_q    <= 1'b0;
        end else begin
            en_meta_q  <= en;
            en_s_q     <= en_meta_q;
            ocd_meta_q <= ocd;
            ocd_s_q    <= ocd_meta_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ph_q     <= 1'b0;
            dcnt_q   <= '0;
            otc_q    <= '0;
            wdc_q    <= '0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            dcnt_q   <= dcnt_d;
            otc_q    <= otc_d;
            wdc_q    <= wdc_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

`ifdef BRIDGE_DRV_HALFCYCLE_CNT_EN
    // Half-cycle counter register; holds after the burst until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc_q <= '0;
        end else begin
            hc_q <= hc_d;
        end
    end

    assign halfcycles = hc_q;
`endif

    // Next-state logic; ocd_s overrides everything, outputs are decoded from the state being entered.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        dcnt_d  = dcnt_q;
        otc_d   = otc_q;
        wdc_d   = wdc_q;
`ifdef BRIDGE_DRV_HALFCYCLE_CNT_EN
        hc_d    = hc_q;
`endif
        stop_req = !en_s_q || (otc_q >= ontime);
        fb_edge  = (sgn_pre != ph_q);
        otc_inc  = (otc_q == OTC_MAX) ? otc_q : otc_q + OW'(1);

        if (ocd_s_q) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_s_q) begin
                        ph_d    = sgn_pre;
                        dcnt_d  = deadtime;
                        otc_d   = '0;
`ifdef BRIDGE_DRV_HALFCYCLE_CNT_EN
                        hc_d    = '0;
`endif
                        state_d = ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    // Phase keeps tracking feedback so DRIVE starts on the current polarity.
                    ph_d  = sgn_pre;
                    otc_d = otc_inc;
                    wdc_d = '0;
                    if (dcnt_q <= DW'(1)) begin
                        state_d = ST_DRIVE;
`ifdef BRIDGE_DRV_HALFCYCLE_CNT_EN
                        if (hc_q != '1) begin
                            hc_d = hc_q + OW'(1);
                        end
`endif
                    end else begin
                        dcnt_d = dcnt_q - DW'(1);
                    end
                end
                ST_DRIVE: begin
                    otc_d = otc_inc;
                    wdc_d = wdc_q + WW'(1);
                    if (fb_edge) begin
                        // A stop is only honoured on a feedback edge, i.e. at a current zero crossing.
                        if (stop_req) begin
                            state_d = ST_IDLE;
                        end else begin
                            ph_d    = sgn_pre;
                            dcnt_d  = deadtime;
                            state_d = ST_DEAD;
                        end
                    end else if (wdc_q == WD_LAST) begin
                        // Feedback lost: abandon the burst quietly, not a fault.
                        state_d = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    // Latched until the operator also removes enable.
                    if (!en_s_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        gate_a_d = (state_d == ST_DRIVE) &&  ph_d;
        gate_b_d = (state_d == ST_DRIVE) && !ph_d;
        busy_d   = (state_d == ST_DEAD) || (state_d == ST_DRIVE);
        fault_d  = (state_d == ST_FAULT);
    end

    assign gate_a = gate_a_q;
    assign gate_b = gate_b_q;
    assign busy   = busy_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_bridge_drv.sv
// Purpose : bench for bridge_drv; burst summaries expected at stimulus time are compared when busy falls.
// Latency : feedback is a 100-cycle square wave with edges on multiples of 50 bench cycles.
// Backpressure: n/a.
module tb_bridge_drv;

    localparam int DW = 8;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sgn_pre;
    logic          en;
    logic          ocd;
    logic [DW-1:0] deadtime;
    logic [OW-1:0] ontime;
    logic          gate_a;
    logic          gate_b;
    logic          busy;
    logic          fault;
`ifdef BRIDGE_DRV_HALFCYCLE_CNT_EN
    logic [OW-1:0] halfcycles;
`endif

    bridge_drv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sgn_pre    (sgn_pre),
        .en         (en),
        .ocd        (ocd),
        .deadtime   (deadtime),
        .ontime     (ontime),
        .gate_a     (gate_a),
        .gate_b     (gate_b),
        .busy       (busy),
        .fault      (fault)
`ifdef BRIDGE_DRV_HALFCYCLE_CNT_EN
        , .halfcycles (halfcycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;   // first cycle with busy=1
        int e;   // first cycle with busy=0 again
        int ng;  // number of dead-time gaps (initial one included)
        int g;   // required length of every gap
        int f;   // fault level in the cycle busy drops
    } burst_t;

    burst_t exp_q[$];
    int     cyc      = 0;
    bit     sq_hold  = 1'b0;
    int     n_checks = 0;
    int     n_errs   = 0;
    int     overlaps = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!sq_hold) sgn_pre = (((cyc / 50) % 2) == 1);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // Burst starting (busy) at cycle s with gap g; en_s is low from loff; ends at
    // the first feedback edge in DRIVE where en_s is low or on-time is used up.
    task automatic push_burst(input int s, input int g, input int loff, input int ot);
        int first;
        int c;
        burst_t b;
        first = ((s + g + 49) / 50) * 50;
        c = first;
        while (!(c >= loff || (c - s) >= ot)) c += 50;
        b.s = s; b.e = c + 1; b.ng = 1 + (c - first) / 50; b.g = g; b.f = 0;
        exp_q.push_back(b);
    endtask

    task automatic push_fixed(input int s, input int e, input int ng, input int g, input int f);
        burst_t b;
        b.s = s; b.e = e; b.ng = ng; b.g = g; b.f = f;
        exp_q.push_back(b);
    endtask

    // Output monitor: measures each burst and scores it against the queue.
    bit prev_busy = 1'b0;
    int m_start, m_run, m_ng, m_gmin, m_gmax;
    always @(negedge clk) begin
        burst_t e;
        if (gate_a === 1'b1 && gate_b === 1'b1) overlaps++;
        if (busy === 1'b1) begin
            if (!prev_busy) begin
                m_start = cyc; m_run = 0; m_ng = 0; m_gmin = 1 << 30; m_gmax = 0;
            end
            if (gate_a === 1'b0 && gate_b === 1'b0) begin
                m_run++;
            end else if (m_run > 0) begin
                m_ng++;
                if (m_run < m_gmin) m_gmin = m_run;
                if (m_run > m_gmax) m_gmax = m_run;
                m_run = 0;
            end
        end else if (prev_busy) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_burst", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("burst_start", m_start, e.s);
                check("burst_end", cyc, e.e);
                check("burst_gaps", m_ng, e.ng);
                check("gap_min", m_gmin, e.g);
                check("gap_max", m_gmax, e.g);
                check("burst_fault", int'(fault === 1'b1), e.f);
            end
        end
        prev_busy = (busy === 1'b1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; ocd = 1'b0; sgn_pre = 1'b0;
        deadtime = 8'd10; ontime = 16'd1000;
        tick(); tick(); tick();
        check("rst_gate_a", int'(gate_a), 0);
        check("rst_gate_b", int'(gate_b), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fault", int'(fault), 0);
        rst_n = 1'b1;

        // Normal burst stopped by en, dead time 10.
        wait_until(70);
        en = 1'b1;
        push_burst(73, 10, 672, 1000);
        wait_until(670);
        en = 1'b0;
        wait_until(720);

        // On-time limit 250 with en held: stop, one idle cycle, restart.
        ontime = 16'd250;
        wait_until(770);
        en = 1'b1;
        push_burst(773, 10, 1 << 30, 250);
        wait_until(1051);
        check("ontime_idle_busy", int'(busy), 0);
`ifdef BRIDGE_DRV_HALFCYCLE_CNT_EN
        check("halfcycles", int'(halfcycles), 6);
`endif
        wait_until(1070);
        en = 1'b0;
        push_burst(1052, 10, 1072, 250);
        wait_until(1120);

        // Zero dead time still yields one both-low cycle.
        ontime = 16'd1000;
        deadtime = 8'd0;
        wait_until(1170);
        en = 1'b1;
        push_burst(1173, 1, 1372, 1000);
        wait_until(1370);
        en = 1'b0;
        wait_until(1420);

        // Overcurrent mid-DRIVE, latched until en also drops.
        deadtime = 8'd10;
        wait_until(1470);
        en = 1'b1;
        push_fixed(1473, 1573, 3, 10, 1);
        wait_until(1570);
        ocd = 1'b1;
        wait_until(1572);
        check("ocd_pre_busy", int'(busy), 1);
        check("ocd_pre_fault", int'(fault), 0);
        tick();
        check("ocd_gate_a", int'(gate_a), 0);
        check("ocd_gate_b", int'(gate_b), 0);
        check("ocd_fault", int'(fault), 1);
        wait_until(1580);
        ocd = 1'b0;
        wait_until(1590);
        check("fault_held_en", int'(fault), 1);
        en = 1'b0;
        wait_until(1592);
        check("fault_before_exit", int'(fault), 1);
        tick();
        check("fault_cleared", int'(fault), 0);
        check("fault_exit_busy", int'(busy), 0);

        // Lost feedback: watchdog ends DRIVE after 1023 cycles without fault.
        wait_until(1600);
        deadtime = 8'd5;
        wait_until(1620);
        sq_hold = 1'b1;
        en = 1'b1;
        push_fixed(1623, 2651, 1, 5, 0);
        wait_until(1700);
        en = 1'b0;
        wait_until(2651);
        check("wd_busy", int'(busy), 0);
        check("wd_fault", int'(fault), 0);
        wait_until(2660);
        sq_hold = 1'b0;
        deadtime = 8'd10;

        // One-cycle reset mid-DRIVE, then a fresh burst with en held.
        wait_until(2720);
        en = 1'b1;
        push_fixed(2723, 2821, 3, 10, 0);
        wait_until(2820);
        rst_n = 1'b0;
        tick();
        check("mid_rst_gate_a", int'(gate_a), 0);
        check("mid_rst_gate_b", int'(gate_b), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_fault", int'(fault), 0);
        rst_n = 1'b1;
        push_burst(2824, 10, 2952, 1000);
        wait_until(2950);
        en = 1'b0;
        wait_until(3020);

        check("sb_drained", exp_q.size(), 0);
        check("no_overlap", overlaps, 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
